// File: rtl/ones_comp_accum_if.sv
// ones_comp_accum_if: operand stream in, folded ones'-complement result out.
interface ones_comp_accum_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_sub;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_ovf;
    modport master (
        output start, in_valid, in_data, in_sub, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_ovf
    );
    modport slave (
        input  start, in_valid, in_data, in_sub, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_ovf
    );
endinterface

// File: rtl/ones_comp_accum.sv
// ones_comp_accum: streaming ones'-complement add/sub accumulator with end-around-carry fold.
// Define ONES_NEGZERO_NORM_EN to report a negative-zero (all-ones) result as all-zeros.
module ones_comp_accum #(
    parameter int WIDTH      = 16,
    parameter int CARRY_BITS = 8
) (
    input logic clk,
    input logic rst,
    ones_comp_accum_if.slave bus
);
    localparam int ACC_W = WIDTH + CARRY_BITS;
    localparam logic [1:0] IDLE = 2'd0, ACCUM = 2'd1, FOLD = 2'd2, DONE = 2'd3;
    localparam logic [CARRY_BITS:0] CNT_MAX = {1'b1, {CARRY_BITS{1'b0}}};
    logic [1:0]            state_q, state_d;
    logic [ACC_W-1:0]      acc_q, acc_d;
    logic [CARRY_BITS:0]   cnt_q, cnt_d;
    logic                  ovf_q, ovf_d;
    logic                  valid_q, valid_d;
    logic [WIDTH-1:0]      sum_q, sum_d;
    logic [WIDTH-1:0]      lo, lo_out, operand;
    logic [CARRY_BITS-1:0] hi;
    assign lo      = acc_q[WIDTH-1:0];
    assign hi      = acc_q[ACC_W-1:WIDTH];
    assign operand = bus.in_sub ? ~bus.in_data : bus.in_data;
`ifdef ONES_NEGZERO_NORM_EN
    assign lo_out = &lo ? '0 : lo;
`else
    assign lo_out = lo;
`endif
    assign bus.in_ready  = state_q == ACCUM;
    assign bus.out_valid = valid_q;
    assign bus.out_sum   = sum_q;
    assign bus.out_ovf   = ovf_q;
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        valid_d = valid_q;
        sum_d   = sum_q;
        case (state_q)
            IDLE, ACCUM: begin
                if (bus.start) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = ACCUM;
                end else if (state_q == ACCUM && bus.in_valid) begin
                    acc_d   = acc_q + ACC_W'(operand);
                    cnt_d   = cnt_q == CNT_MAX ? cnt_q : cnt_q + (CARRY_BITS+1)'(1);
                    ovf_d   = ovf_q | (cnt_q == CNT_MAX);
                    state_d = bus.in_last ? FOLD : ACCUM;
                end
            end
            // Fold until the guard bits are empty; the check itself costs the final cycle.
            FOLD: begin
                if (hi == '0) begin
                    sum_d   = lo_out;
                    valid_d = 1'b1;
                    state_d = DONE;
                end else begin
                    acc_d = ACC_W'(lo) + ACC_W'(hi);
                end
            end
            default: begin
                if (bus.out_ready) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
            sum_q   <= sum_d;
        end
    end
endmodule
